// File: rtl/frv_lsu_split_pkg.sv
// Shared types and constants for the frv load/store unit.
//   lsu_state_e : request sequencer states
//   SIZE_MASK_* : per-size byte masks before lane shifting
//   size_mask() : decode of the one-hot size inputs into a byte mask
package frv_lsu_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] SIZE_MASK_BYTE = 4'h1;
    localparam logic [3:0] SIZE_MASK_HALF = 4'h3;
    localparam logic [3:0] SIZE_MASK_WORD = 4'hF;

    // Byte mask for the access size; no size selected yields an empty mask.
    function automatic logic [3:0] size_mask(input logic is_byte,
                                             input logic is_half,
                                             input logic is_word);
        logic [3:0] m;
        if (is_byte) begin
            m = SIZE_MASK_BYTE;
        end else if (is_half) begin
            m = SIZE_MASK_HALF;
        end else if (is_word) begin
            m = SIZE_MASK_WORD;
        end else begin
            m = 4'h0;
        end
        return m;
    endfunction

endpackage

// File: rtl/frv_lsu_split_align.sv
// Combinational lane logic for the frv LSU.
//   off_i        : byte offset of the access within its word
//   size_mask_i  : unshifted byte mask (1/3/F)
//   byte_i/half_i: access size, used for load extension
//   signed_i     : sign-extend byte/half loads
//   wdata_i      : LSB-aligned store data
//   rdata64_i    : two-word load data window (low word = first beat)
//   strb8_o      : byte strobes across both beats
//   wdata64_o    : lane-positioned store data across both beats
//   rdata_o      : aligned and extended load result
module frv_lsu_split_align
    import frv_lsu_split_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [3:0]  size_mask_i,
    input  logic        byte_i,
    input  logic        half_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] rdata64_i,
    output logic [7:0]  strb8_o,
    output logic [63:0] wdata64_o,
    output logic [31:0] rdata_o
);

    logic [63:0] shifted_s;

    // Store lanes move up by the byte offset; load data moves down by it.
    always_comb begin
        strb8_o   = {4'h0, size_mask_i} << off_i;
        wdata64_o = {32'h0000_0000, wdata_i} << {off_i, 3'b000};
        shifted_s = rdata64_i >> {off_i, 3'b000};
        if (byte_i) begin
            rdata_o = signed_i ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                               : {24'h00_0000, shifted_s[7:0]};
        end else if (half_i) begin
            rdata_o = signed_i ? {{16{shifted_s[15]}}, shifted_s[15:0]}
                               : {16'h0000, shifted_s[15:0]};
        end else begin
            rdata_o = shifted_s[31:0];
        end
    end

endmodule

// File: rtl/frv_lsu_split.sv
// frv load/store unit with load return path and misaligned-access splitting.
// One transaction outstanding; boundary-crossing accesses become two aligned
// word beats when MISALIGN_SPLIT=1, otherwise they raise lsu_a_error.
//   Pipeline side : lsu_valid/addr/wdata/op decode in, pipe_prog, hold_lsu_req;
//                   lsu_ready, lsu_a_error, lsu_b_error, lsu_mmio, lsu_rdata out
//   MMIO port     : single-cycle mmio_en/wen/addr/wdata, mmio_rdata same cycle
//   dmem bus      : dmem_req/wen/strb/addr/wdata, dmem_gnt, then
//                   dmem_rvalid/rdata/error for each granted beat
module frv_lsu_split
    import frv_lsu_split_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        lsu_valid,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic        lsu_load,
    input  logic        lsu_store,
    input  logic        lsu_byte,
    input  logic        lsu_half,
    input  logic        lsu_word,
    input  logic        lsu_signed,
    input  logic        pipe_prog,
    input  logic        hold_lsu_req,
    output logic        lsu_ready,
    output logic        lsu_a_error,
    output logic        lsu_b_error,
    output logic        lsu_mmio,
    output logic [31:0] lsu_rdata,
    output logic        mmio_en,
    output logic        mmio_wen,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_wdata,
    input  logic [31:0] mmio_rdata,
    output logic        dmem_req,
    output logic        dmem_wen,
    output logic [3:0]  dmem_strb,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_error
);

    lsu_state_e  state_q, state_d;
    logic        beat_q, beat_d;
    logic [63:0] rbuf_q, rbuf_d;
    logic        b_err_q, b_err_d;
    logic        a_err_q, a_err_d;

    logic [3:0]  mask_s;
    logic [7:0]  strb8_s;
    logic [63:0] w64_s;
    logic [63:0] ld_raw_s;
    logic [63:0] rbuf_wr_s;
    logic [31:0] ld_ext_s;
    logic        cross_s;
    logic        misalign_s;
    logic        mmio_hit_s;
    logic        a_err_s;
    logic        rsp_done_s;
    logic        ready_s;
    logic        mmio_en_s;

    assign mask_s = size_mask(lsu_byte, lsu_half, lsu_word);

    frv_lsu_split_align u_align (
        .off_i       (lsu_addr[1:0]),
        .size_mask_i (mask_s),
        .byte_i      (lsu_byte),
        .half_i      (lsu_half),
        .signed_i    (lsu_signed),
        .wdata_i     (lsu_wdata),
        .rdata64_i   (ld_raw_s),
        .strb8_o     (strb8_s),
        .wdata64_o   (w64_s),
        .rdata_o     (ld_ext_s)
    );

    // Access classification: crossing, misalignment, MMIO decode, address error.
    // A crossing access is always misaligned, so with splitting disabled no
    // crossing access ever reaches the bus.
    always_comb begin
        cross_s    = |strb8_s[7:4];
        misalign_s = (lsu_half && lsu_addr[0]) ||
                     (lsu_word && (lsu_addr[1:0] != 2'b00));
        mmio_hit_s = lsu_valid && ((lsu_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR);
        a_err_s    = lsu_valid && misalign_s &&
                     ((MISALIGN_SPLIT == 1'b0) || mmio_hit_s);
        rsp_done_s = (state_q == ST_RSP) && dmem_rvalid;
        if (beat_q) begin
            rbuf_wr_s = {dmem_rdata, rbuf_q[31:0]};
        end else begin
            rbuf_wr_s = {rbuf_q[63:32], dmem_rdata};
        end
    end

    // Load data window: live MMIO data, the beat completing now, or the buffer.
    always_comb begin
        if (state_q == ST_IDLE) begin
            ld_raw_s = {32'h0000_0000, mmio_rdata};
        end else if (rsp_done_s) begin
            ld_raw_s = rbuf_wr_s;
        end else begin
            ld_raw_s = rbuf_q;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rbuf_d    = rbuf_q;
        b_err_d   = b_err_q;
        a_err_d   = a_err_q;
        ready_s   = 1'b0;
        mmio_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!lsu_valid) begin
                    state_d = ST_IDLE;
                end else if (a_err_s) begin
                    // Completes immediately; park in DONE unless the pipe moves now.
                    ready_s = 1'b1;
                    if (!pipe_prog) begin
                        state_d = ST_DONE;
                        a_err_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (hold_lsu_req) begin
                    state_d = ST_IDLE;
                end else if (mmio_hit_s) begin
                    mmio_en_s = 1'b1;
                    ready_s   = 1'b1;
                    rbuf_d    = {32'h0000_0000, mmio_rdata};
                    if (!pipe_prog) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_REQ;
                    beat_d  = 1'b0;
                    rbuf_d  = 64'h0;
                    b_err_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    state_d = ST_RSP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RSP: begin
                if (dmem_rvalid) begin
                    rbuf_d  = rbuf_wr_s;
                    b_err_d = b_err_q | dmem_error;
                    // Second beat goes out even when the first one errored.
                    if (cross_s && !beat_q) begin
                        beat_d  = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        ready_s = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_RSP;
                end
            end
            ST_DONE: begin
                ready_s = 1'b1;
                if (pipe_prog) begin
                    state_d = ST_IDLE;
                    beat_d  = 1'b0;
                    b_err_d = 1'b0;
                    a_err_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            beat_q  <= 1'b0;
            rbuf_q  <= 64'h0;
            b_err_q <= 1'b0;
            a_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rbuf_q  <= rbuf_d;
            b_err_q <= b_err_d;
            a_err_q <= a_err_d;
        end
    end

    // Output drive; everything idles at zero outside its qualifying state.
    always_comb begin
        lsu_ready   = ready_s;
        lsu_mmio    = mmio_hit_s;
        lsu_a_error = ((state_q == ST_IDLE) && a_err_s) ||
                      ((state_q == ST_DONE) && a_err_q);
        lsu_b_error = ready_s && (b_err_q || (rsp_done_s && dmem_error));
        lsu_rdata   = (ready_s && lsu_load) ? ld_ext_s : 32'h0000_0000;
        mmio_en     = mmio_en_s;
        mmio_wen    = mmio_en_s && lsu_store;
        mmio_addr   = mmio_en_s ? lsu_addr : 32'h0000_0000;
        mmio_wdata  = mmio_en_s ? lsu_wdata : 32'h0000_0000;
        dmem_req    = (state_q == ST_REQ);
        if (state_q == ST_REQ) begin
            dmem_wen   = lsu_store;
            dmem_addr  = {lsu_addr[31:2], 2'b00} + (beat_q ? 32'd4 : 32'd0);
            dmem_strb  = beat_q ? strb8_s[7:4] : strb8_s[3:0];
            dmem_wdata = beat_q ? w64_s[63:32] : w64_s[31:0];
        end else begin
            dmem_wen   = 1'b0;
            dmem_addr  = 32'h0000_0000;
            dmem_strb  = 4'h0;
            dmem_wdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_frv_lsu_split.sv
// Directed self-checking bench for frv_lsu_split. A second instance built with
// MISALIGN_SPLIT=0 shares every input except its own request valid.
module tb_frv_lsu_split;
    import frv_lsu_split_pkg::*;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        lsu_valid, lsu_valid0;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_load, lsu_store, lsu_byte, lsu_half, lsu_word, lsu_signed;
    logic        pipe_prog, hold_lsu_req;
    logic [31:0] mmio_rdata;
    logic        dmem_gnt, dmem_rvalid, dmem_error;
    logic [31:0] dmem_rdata;

    logic        lsu_ready, lsu_a_error, lsu_b_error, lsu_mmio;
    logic [31:0] lsu_rdata;
    logic        mmio_en, mmio_wen;
    logic [31:0] mmio_addr, mmio_wdata;
    logic        dmem_req, dmem_wen;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata;

    logic        lsu_ready0, lsu_a_error0, lsu_b_error0, lsu_mmio0;
    logic [31:0] lsu_rdata0;
    logic        mmio_en0, mmio_wen0;
    logic [31:0] mmio_addr0, mmio_wdata0;
    logic        dmem_req0, dmem_wen0;
    logic [3:0]  dmem_strb0;
    logic [31:0] dmem_addr0, dmem_wdata0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 g_clk = ~g_clk;

    frv_lsu_split #(.MISALIGN_SPLIT(1'b1)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .lsu_valid(lsu_valid),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_load(lsu_load),
        .lsu_store(lsu_store), .lsu_byte(lsu_byte), .lsu_half(lsu_half),
        .lsu_word(lsu_word), .lsu_signed(lsu_signed), .pipe_prog(pipe_prog),
        .hold_lsu_req(hold_lsu_req), .lsu_ready(lsu_ready),
        .lsu_a_error(lsu_a_error), .lsu_b_error(lsu_b_error), .lsu_mmio(lsu_mmio),
        .lsu_rdata(lsu_rdata), .mmio_en(mmio_en), .mmio_wen(mmio_wen),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error)
    );

    frv_lsu_split #(.MISALIGN_SPLIT(1'b0)) dut0 (
        .g_clk(g_clk), .g_resetn(g_resetn), .lsu_valid(lsu_valid0),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_load(lsu_load),
        .lsu_store(lsu_store), .lsu_byte(lsu_byte), .lsu_half(lsu_half),
        .lsu_word(lsu_word), .lsu_signed(lsu_signed), .pipe_prog(pipe_prog),
        .hold_lsu_req(hold_lsu_req), .lsu_ready(lsu_ready0),
        .lsu_a_error(lsu_a_error0), .lsu_b_error(lsu_b_error0), .lsu_mmio(lsu_mmio0),
        .lsu_rdata(lsu_rdata0), .mmio_en(mmio_en0), .mmio_wen(mmio_wen0),
        .mmio_addr(mmio_addr0), .mmio_wdata(mmio_wdata0), .mmio_rdata(mmio_rdata),
        .dmem_req(dmem_req0), .dmem_wen(dmem_wen0), .dmem_strb(dmem_strb0),
        .dmem_addr(dmem_addr0), .dmem_wdata(dmem_wdata0), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error)
    );

    // The core never advances the pipe while a bus beat is in flight.
    always @(negedge g_clk) begin
        if (g_resetn && pipe_prog) begin
            assert (dut.state_q != ST_REQ && dut.state_q != ST_RSP &&
                    dut0.state_q != ST_REQ && dut0.state_q != ST_RSP)
            else $error("FAIL pipe_prog_in_flight");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    // sz: 0 byte, 1 half, 2 word
    task automatic set_op(input logic [31:0] addr, input logic [31:0] wd,
                          input logic st, input int sz, input logic sgn,
                          input logic v, input logic v0);
        lsu_addr   = addr;
        lsu_wdata  = wd;
        lsu_load   = !st;
        lsu_store  = st;
        lsu_byte   = (sz == 0);
        lsu_half   = (sz == 1);
        lsu_word   = (sz == 2);
        lsu_signed = sgn;
        lsu_valid  = v;
        lsu_valid0 = v0;
    endtask

    // Wait (bounded) for a request, check it, grant it; returns in the RSP cycle.
    task automatic issue_beat(input string tag, input logic [31:0] ea, input logic [3:0] es,
                              input logic [31:0] ew, input logic ewen);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge g_clk);
            if (dmem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " req"}, {31'h0, seen}, 32'd1);
        check({tag, " addr"}, dmem_addr, ea);
        check({tag, " strb"}, {28'h0, dmem_strb}, {28'h0, es});
        check({tag, " wdata"}, dmem_wdata, ew);
        check({tag, " wen"}, {31'h0, dmem_wen}, {31'h0, ewen});
        dmem_gnt = 1'b1;
        cyc();
        dmem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd, input logic err);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd;
        dmem_error  = err;
    endtask

    task automatic end_rsp();
        cyc();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        dmem_error  = 1'b0;
    endtask

    task automatic release_op();
        pipe_prog = 1'b1;
        cyc();
        pipe_prog = 1'b0;
        set_op(32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        lsu_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        g_resetn = 1'b0; pipe_prog = 1'b0; hold_lsu_req = 1'b0; mmio_rdata = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_error = 1'b0; dmem_rdata = 32'h0;
        set_op(32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        @(negedge g_clk);
        check("rst ready", {31'h0, lsu_ready}, 32'd0);
        check("rst req", {31'h0, dmem_req}, 32'd0);
        check("rst rdata", lsu_rdata, 32'h0);
        check("rst mmio_en", {31'h0, mmio_en}, 32'd0);
        check("rst errs", {30'h0, lsu_a_error, lsu_b_error}, 32'd0);
        cyc();
        g_resetn = 1'b1;
        cyc();

        // LW aligned, single beat, ready held until pipe_prog
        set_op(32'h100, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        issue_beat("lw", 32'h100, 4'hF, 32'h0, 1'b0);
        respond(32'hDEAD_BEEF, 1'b0);
        @(negedge g_clk);
        check("lw ready", {31'h0, lsu_ready}, 32'd1);
        check("lw rdata", lsu_rdata, 32'hDEAD_BEEF);
        check("lw berr", {31'h0, lsu_b_error}, 32'd0);
        end_rsp();
        @(negedge g_clk);
        check("lw done rdata", lsu_rdata, 32'hDEAD_BEEF);
        cyc();
        @(negedge g_clk);
        check("lw held", {31'h0, lsu_ready}, 32'd1);
        release_op();
        @(negedge g_clk);
        check("lw released", {31'h0, lsu_ready}, 32'd0);
        cyc();

        // LB signed / LBU at offset 3
        set_op(32'h103, 32'h0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        issue_beat("lb", 32'h100, 4'h8, 32'h0, 1'b0);
        respond(32'h8012_3456, 1'b0);
        @(negedge g_clk);
        check("lb rdata", lsu_rdata, 32'hFFFF_FF80);
        end_rsp();
        release_op();
        set_op(32'h103, 32'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        issue_beat("lbu", 32'h100, 4'h8, 32'h0, 1'b0);
        respond(32'h8012_3456, 1'b0);
        end_rsp();
        @(negedge g_clk);
        check("lbu rdata", lsu_rdata, 32'h0000_0080);
        release_op();

        // SW split across words
        set_op(32'h102, 32'h1122_3344, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        issue_beat("sw b0", 32'h100, 4'hC, 32'h3344_0000, 1'b1);
        respond(32'h0, 1'b0);
        @(negedge g_clk);
        check("sw mid ready", {31'h0, lsu_ready}, 32'd0);
        end_rsp();
        issue_beat("sw b1", 32'h104, 4'h3, 32'h0000_1122, 1'b1);
        respond(32'h0, 1'b0);
        @(negedge g_clk);
        check("sw ready", {31'h0, lsu_ready}, 32'd1);
        check("sw berr", {31'h0, lsu_b_error}, 32'd0);
        end_rsp();
        release_op();

        // LW split at offset 1
        set_op(32'h101, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        issue_beat("lw1 b0", 32'h100, 4'hE, 32'h0, 1'b0);
        respond(32'h4433_2211, 1'b0);
        end_rsp();
        issue_beat("lw1 b1", 32'h104, 4'h1, 32'h0, 1'b0);
        respond(32'h8877_6655, 1'b0);
        @(negedge g_clk);
        check("lw1 rdata", lsu_rdata, 32'h5544_3322);
        end_rsp();
        @(negedge g_clk);
        check("lw1 done rdata", lsu_rdata, 32'h5544_3322);
        release_op();

        // Same access with splitting disabled
        set_op(32'h101, 32'h0, 1'b0, 2, 1'b0, 1'b0, 1'b1);
        @(negedge g_clk);
        check("ns aerr", {31'h0, lsu_a_error0}, 32'd1);
        check("ns ready", {31'h0, lsu_ready0}, 32'd1);
        check("ns req", {31'h0, dmem_req0}, 32'd0);
        cyc();
        @(negedge g_clk);
        check("ns held aerr", {30'h0, lsu_a_error0, lsu_ready0}, 32'd3);
        check("ns held req", {31'h0, dmem_req0}, 32'd0);
        release_op();

        // MMIO store
        set_op(32'h1004, 32'hCAFE_F00D, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        @(negedge g_clk);
        check("mmio sw en/wen", {30'h0, mmio_en, mmio_wen}, 32'd3);
        check("mmio sw addr", mmio_addr, 32'h1004);
        check("mmio sw wdata", mmio_wdata, 32'hCAFE_F00D);
        check("mmio sw ready/mmio", {30'h0, lsu_ready, lsu_mmio}, 32'd3);
        check("mmio sw req", {31'h0, dmem_req}, 32'd0);
        cyc();
        @(negedge g_clk);
        check("mmio sw after", {29'h0, mmio_en, lsu_ready, dmem_req}, 32'd2);
        release_op();

        // MMIO load
        set_op(32'h1000, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        mmio_rdata = 32'h1234_5678;
        @(negedge g_clk);
        check("mmio lw rdata", lsu_rdata, 32'h1234_5678);
        cyc();
        mmio_rdata = 32'h0;
        @(negedge g_clk);
        check("mmio lw held", lsu_rdata, 32'h1234_5678);
        release_op();

        // Misaligned MMIO half
        set_op(32'h1001, 32'h0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        @(negedge g_clk);
        check("mmio lh aerr", {29'h0, lsu_a_error, lsu_ready, mmio_en}, 32'd6);
        check("mmio lh req", {31'h0, dmem_req}, 32'd0);
        release_op();

        // Address wrap on second beat
        set_op(32'hFFFF_FFFE, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        issue_beat("wrap b0", 32'hFFFF_FFFC, 4'hC, 32'h0, 1'b0);
        respond(32'h2211_0000, 1'b0);
        end_rsp();
        issue_beat("wrap b1", 32'h0000_0000, 4'h3, 32'h0, 1'b0);
        respond(32'h0000_4433, 1'b0);
        @(negedge g_clk);
        check("wrap rdata", lsu_rdata, 32'h4433_2211);
        end_rsp();
        release_op();

        // Bus error on beat 0 of a split load
        set_op(32'h102, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        issue_beat("berr b0", 32'h100, 4'hC, 32'h0, 1'b0);
        respond(32'h0, 1'b1);
        end_rsp();
        issue_beat("berr b1", 32'h104, 4'h3, 32'h0, 1'b0);
        respond(32'h0, 1'b0);
        @(negedge g_clk);
        check("berr ready/berr", {30'h0, lsu_ready, lsu_b_error}, 32'd3);
        end_rsp();
        @(negedge g_clk);
        check("berr held", {31'h0, lsu_b_error}, 32'd1);
        release_op();
        @(negedge g_clk);
        check("berr cleared", {30'h0, lsu_ready, lsu_b_error}, 32'd0);
        cyc();

        // hold_lsu_req blocks entry from IDLE
        hold_lsu_req = 1'b1;
        set_op(32'h200, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        cyc(); cyc();
        @(negedge g_clk);
        check("hold req", {30'h0, dmem_req, lsu_ready}, 32'd0);
        hold_lsu_req = 1'b0;
        issue_beat("hold go", 32'h200, 4'hF, 32'h0, 1'b0);
        respond(32'h0BAD_F00D, 1'b0);
        @(negedge g_clk);
        check("hold rdata", lsu_rdata, 32'h0BAD_F00D);
        end_rsp();
        release_op();

        // Reset while waiting for a response
        set_op(32'h101, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        issue_beat("rstrsp", 32'h100, 4'hE, 32'h0, 1'b0);
        g_resetn = 1'b0;
        lsu_valid = 1'b0;
        cyc();
        @(negedge g_clk);
        check("rstrsp outs", {28'h0, dmem_req, lsu_ready, lsu_a_error, lsu_b_error}, 32'd0);
        check("rstrsp rdata", lsu_rdata, 32'h0);
        g_resetn = 1'b1;
        cyc();
        set_op(32'h100, 32'h0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        issue_beat("post rst", 32'h100, 4'hF, 32'h0, 1'b0);
        respond(32'h5A5A_5A5A, 1'b0);
        @(negedge g_clk);
        check("post rst rdata", lsu_rdata, 32'h5A5A_5A5A);
        end_rsp();
        release_op();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
